hog_svm_acc: RTL
================

HOG_SVM_ACC -- requirements
Module: hog_svm_acc

Interface
REQ-001 SHALL have parameter FEA_W, default 12, meaning unsigned feature width (Q4.8).
REQ-002 SHALL have parameter W_W, default 16, meaning signed SVM weight width (Q4.12).
REQ-003 SHALL have parameter FEA_PER_BLK, default 36, meaning features per block.
REQ-004 SHALL have parameter BLK_PER_WIN, default 105, meaning blocks per detection window.
REQ-005 SHALL have parameter ACC_W, default 40, meaning signed accumulator and score width.
REQ-006 SHALL have port clk, input, 1 bit: clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port clear, input, 1 bit: synchronous window restart (frame start).
REQ-009 SHALL have port fea, input, FEA_W bits: normalized feature.
REQ-010 SHALL have port i_valid, input, 1 bit: fea valid this cycle; there is no backpressure.
REQ-011 SHALL have port bias, input, ACC_W bits, signed: SVM bias, static during a window.
REQ-012 SHALL have port w_addr, output, 12 bits: weight ROM address.
REQ-013 SHALL have port w_data, input, W_W bits, signed: ROM data, valid 1 cycle after w_addr.
REQ-014 SHALL have port score, output, ACC_W bits, signed: window score.
REQ-015 SHALL have port detect, output, 1 bit: score > 0.
REQ-016 SHALL have port o_valid, output, 1 bit: one-cycle pulse when score/detect are updated.

Function
REQ-017 SHALL keep counters fea_idx (0..FEA_PER_BLK-1) and blk_idx (0..BLK_PER_WIN-1), advanced only on accepted i_valid.
REQ-018 SHALL drive w_addr = blk_idx*FEA_PER_BLK + fea_idx combinationally from the counters, so weight index k pairs with the k-th feature of the window.
REQ-019 SHALL use pipeline S1 = register fea and i_valid while the ROM returns w_data; S2 = register the signed product of zero-extended fea and w_data (FEA_W+W_W bits); S3 = accumulate.
REQ-020 SHALL sign-extend the product to ACC_W before accumulation, with no saturation (ACC_W=40 covers 3780 full-scale terms).
REQ-021 SHALL load the accumulator with bias + product at the first term of each window, and add the product for every other term.
REQ-022 SHALL, on the last feature (fea_idx = FEA_PER_BLK-1 and blk_idx = BLK_PER_WIN-1), wrap both counters to 0 in the same cycle.
REQ-023 SHALL, 3 cycles after that last i_valid, register score = final accumulator value and detect = (score > 0, signed), and pulse o_valid for exactly 1 cycle.
REQ-024 SHALL hold score and detect between pulses.
REQ-025 SHALL accept i_valid gaps of any length without effect on the result, and back-to-back windows with no idle cycle; the first term of window n+1 SHALL NOT corrupt the score of window n.
REQ-026 SHALL, on clear, zero both counters and kill all in-flight pipeline valids so that no o_valid results from a partial window; an i_valid in the same cycle as clear SHALL be dropped.
REQ-027 SHALL treat fea_idx and blk_idx as a flat index: the feature wrap at FEA_PER_BLK SHALL increment blk_idx.

Reset
REQ-028 SHALL, with rst low at a clock edge, clear counters, pipeline valids, accumulator, score, detect and o_valid to 0.
REQ-029 SHALL, after reset, drive w_addr = 0.
REQ-030 SHALL, on reset mid-window, discard the partial window, identical to clear.

Structure
REQ-031 SHALL put the FEA_W, W_W, FEA_PER_BLK, BLK_PER_WIN and ACC_W defaults, plus the weight-address width, in the shared HOG package used with normalize.
REQ-032 SHALL implement the S2 multiply in one sub-module, mac_stage (registered signed multiply), to allow DSP mapping.
REQ-033 SHALL instantiate the weight ROM outside this block.

Verification
REQ-034 SHALL cover: all fea=0x100 (1.0), all w=0x1000 (1.0), bias=0 -> score = 3780<<20, detect=1, o_valid exactly 3 cycles after the 3780th i_valid.
REQ-035 SHALL cover: fea=0x100, w=-0x1000, bias=5<<20 -> score = -3775<<20, detect=0.
REQ-036 SHALL cover: random i_valid gaps (0-10 cycles) on the same data as REQ-034 -> identical score, 1 o_valid pulse.
REQ-037 SHALL cover: two back-to-back windows (score A then score B) -> two pulses 3780 cycles apart with correct independent scores.
REQ-038 SHALL cover: clear (or rst low) after 1000 features, then a full window -> only 1 o_valid, score matching the full window alone.
REQ-039 SHALL cover: fea=0xFFF, w=0x7FFF on all terms -> exact unsaturated score = 3780*0xFFF*0x7FFF, and w_addr sequence 0..3779 checked against the counter state.

Source files
------------

// File: rtl/hog_svm_acc_pkg.sv
// Shared HOG constants: default widths/sizes of the feature pipeline and
// the weight-ROM address width, plus the per-term tag carried down the MAC pipe.
package hog_svm_acc_pkg;

    localparam int unsigned HOG_FEA_W       = 12;
    localparam int unsigned HOG_W_W         = 16;
    localparam int unsigned HOG_FEA_PER_BLK = 36;
    localparam int unsigned HOG_BLK_PER_WIN = 105;
    localparam int unsigned HOG_ACC_W       = 40;
    localparam int unsigned HOG_WADDR_W     = 12;

    // Window position of a term: first term loads bias, last term publishes the score.
    typedef struct packed {
        logic first;
        logic last;
    } term_tag_t;

endpackage

// File: rtl/hog_svm_acc_mac_stage.sv
// Registered signed multiply of an unsigned feature by a signed weight,
// with the term's valid and window tag carried alongside.
module mac_stage
    import hog_svm_acc_pkg::*;
#(
    parameter int unsigned FEA_W = HOG_FEA_W,
    parameter int unsigned W_W   = HOG_W_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           kill,
    input  logic                           in_valid,
    input  term_tag_t                      in_tag,
    input  logic [FEA_W-1:0]               fea,
    input  logic signed [W_W-1:0]          w_data,
    output logic                           out_valid,
    output term_tag_t                      out_tag,
    output logic signed [FEA_W+W_W-1:0]    prod
);

    localparam int unsigned P_W = FEA_W + W_W;

    logic signed [P_W-1:0] fea_ext;
    logic signed [P_W-1:0] w_ext;
    logic signed [P_W-1:0] prod_d, prod_q;
    logic                  valid_d, valid_q;
    term_tag_t             tag_d, tag_q;

    // Feature is zero-extended, weight sign-extended; the product always fits P_W bits.
    always_comb begin
        fea_ext = {{W_W{1'b0}}, fea};
        w_ext   = {{FEA_W{w_data[W_W-1]}}, w_data};
        prod_d  = fea_ext * w_ext;
        valid_d = in_valid && !kill;
        tag_d   = in_tag;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data path left without reset so it maps cleanly onto a DSP output register.
    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        tag_q  <= tag_d;
    end

    assign out_valid = valid_q;
    assign out_tag   = tag_q;
    assign prod      = prod_q;

endmodule

// File: rtl/hog_svm_acc.sv
// Linear-SVM scorer for one HOG detection window: streams features, fetches
// the matching weight from an external ROM, and accumulates bias + sum(f*w).
module hog_svm_acc
    import hog_svm_acc_pkg::*;
#(
    parameter int unsigned FEA_W       = HOG_FEA_W,
    parameter int unsigned W_W         = HOG_W_W,
    parameter int unsigned FEA_PER_BLK = HOG_FEA_PER_BLK,
    parameter int unsigned BLK_PER_WIN = HOG_BLK_PER_WIN,
    parameter int unsigned ACC_W       = HOG_ACC_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic [FEA_W-1:0]              fea,
    input  logic                          i_valid,
    input  logic signed [ACC_W-1:0]       bias,
    output logic [HOG_WADDR_W-1:0]        w_addr,
    input  logic signed [W_W-1:0]         w_data,
    output logic signed [ACC_W-1:0]       score,
    output logic                          detect,
    output logic                          o_valid
);

    localparam int unsigned P_W  = FEA_W + W_W;
    localparam int unsigned FI_W = (FEA_PER_BLK > 1) ? $clog2(FEA_PER_BLK) : 1;
    localparam int unsigned BI_W = (BLK_PER_WIN > 1) ? $clog2(BLK_PER_WIN) : 1;

    logic [FI_W-1:0]         fea_idx_q, fea_idx_d;
    logic [BI_W-1:0]         blk_idx_q, blk_idx_d;
    logic [FEA_W-1:0]        fea_s1_q, fea_s1_d;
    logic                    v1_q, v1_d;
    term_tag_t               tag1_q, tag1_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] score_q, score_d;
    logic                    detect_q, detect_d;
    logic                    o_valid_q, o_valid_d;

    logic                    accept;
    logic                    last_fea;
    logic                    last_blk;
    logic                    v2;
    term_tag_t               tag2;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;

    // Flat window index counters and S1 capture of the feature.
    always_comb begin
        accept   = i_valid && !clear;
        last_fea = (fea_idx_q == FI_W'(FEA_PER_BLK - 1));
        last_blk = (blk_idx_q == BI_W'(BLK_PER_WIN - 1));

        fea_idx_d    = fea_idx_q;
        blk_idx_d    = blk_idx_q;
        fea_s1_d     = fea_s1_q;
        v1_d         = accept;
        tag1_d.first = (fea_idx_q == '0) && (blk_idx_q == '0);
        tag1_d.last  = last_fea && last_blk;

        if (clear) begin
            fea_idx_d = '0;
            blk_idx_d = '0;
        end else if (accept) begin
            fea_s1_d = fea;
            if (last_fea) begin
                fea_idx_d = '0;
                blk_idx_d = last_blk ? '0 : blk_idx_q + BI_W'(1);
            end else begin
                fea_idx_d = fea_idx_q + FI_W'(1);
            end
        end

        w_addr = HOG_WADDR_W'(blk_idx_q) * HOG_WADDR_W'(FEA_PER_BLK) + HOG_WADDR_W'(fea_idx_q);
    end

    mac_stage #(
        .FEA_W (FEA_W),
        .W_W   (W_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .kill      (clear),
        .in_valid  (v1_q),
        .in_tag    (tag1_q),
        .fea       (fea_s1_q),
        .w_data    (w_data),
        .out_valid (v2),
        .out_tag   (tag2),
        .prod      (prod)
    );

    // S3: accumulate; the last term publishes in the same edge, so a following
    // window's first term can reload the accumulator without touching score.
    always_comb begin
        prod_ext  = {{(ACC_W - P_W){prod[P_W-1]}}, prod};
        acc_d     = acc_q;
        score_d   = score_q;
        detect_d  = detect_q;
        o_valid_d = 1'b0;

        if (v2 && !clear) begin
            acc_d = tag2.first ? (bias + prod_ext) : (acc_q + prod_ext);
            if (tag2.last) begin
                score_d   = acc_d;
                detect_d  = !acc_d[ACC_W-1] && (acc_d != '0);
                o_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fea_idx_q <= '0;
            blk_idx_q <= '0;
            fea_s1_q  <= '0;
            v1_q      <= 1'b0;
            tag1_q    <= '0;
            acc_q     <= '0;
            score_q   <= '0;
            detect_q  <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            fea_idx_q <= fea_idx_d;
            blk_idx_q <= blk_idx_d;
            fea_s1_q  <= fea_s1_d;
            v1_q      <= v1_d;
            tag1_q    <= tag1_d;
            acc_q     <= acc_d;
            score_q   <= score_d;
            detect_q  <= detect_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign score   = score_q;
    assign detect  = detect_q;
    assign o_valid = o_valid_q;

endmodule
